// File: rtl/stream_demux_1_4.sv
// 1-to-4 valid/ready stream demultiplexer with a one-entry register buffer per output channel.
// Optional per-channel drain counters (cnt0_o..cnt3_o) are enabled by defining STREAM_DEMUX_COUNT_EN.
module stream_demux_1_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [1:0]       in_sel_i,
  output logic [3:0]       out_valid_o,
  input  logic [3:0]       out_ready_i,
  output logic [WIDTH-1:0] out_data0_o,
  output logic [WIDTH-1:0] out_data1_o,
  output logic [WIDTH-1:0] out_data2_o,
  output logic [WIDTH-1:0] out_data3_o
`ifdef STREAM_DEMUX_COUNT_EN
  ,
  output logic [7:0]       cnt0_o,
  output logic [7:0]       cnt1_o,
  output logic [7:0]       cnt2_o,
  output logic [7:0]       cnt3_o
`endif
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ch_state_e;

  ch_state_e        state_q [4];
  ch_state_e        state_d [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [WIDTH-1:0] data_d  [4];
  logic [3:0]       full_s;
  logic [3:0]       acc_s;
  logic [3:0]       drn_s;
  logic             xfer_s;

  // Handshake decode: a full channel may still accept when its sink drains in the same cycle.
  always_comb begin
    full_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      full_s[i] = (state_q[i] == ST_FULL);
    end
    in_ready_o = !full_s[in_sel_i] || out_ready_i[in_sel_i];
    xfer_s     = in_valid_i && in_ready_o;
    if (xfer_s) begin
      acc_s = 4'b0001 << in_sel_i;
    end else begin
      acc_s = 4'b0000;
    end
    drn_s = full_s & out_ready_i;
  end

  // Per-channel next state and buffer load.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      data_d[i]  = data_q[i];
      case (state_q[i])
        ST_EMPTY: begin
          if (acc_s[i]) begin
            state_d[i] = ST_FULL;
            data_d[i]  = in_data_i;
          end else begin
            state_d[i] = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (acc_s[i]) begin
            state_d[i] = ST_FULL;
            data_d[i]  = in_data_i;
          end else if (drn_s[i]) begin
            state_d[i] = ST_EMPTY;
          end else begin
            state_d[i] = ST_FULL;
          end
        end
        default: begin
          state_d[i] = ST_EMPTY;
        end
      endcase
    end
  end

  // Channel state and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= ST_EMPTY;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
      end
    end
  end

  assign out_valid_o = full_s;
  assign out_data0_o = data_q[0];
  assign out_data1_o = data_q[1];
  assign out_data2_o = data_q[2];
  assign out_data3_o = data_q[3];

`ifdef STREAM_DEMUX_COUNT_EN
  logic [7:0] cnt_q [4];

  // Drain counters, free-running with natural 8-bit wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (drn_s[i]) begin
          cnt_q[i] <= cnt_q[i] + 8'd1;
        end else begin
          cnt_q[i] <= cnt_q[i];
        end
      end
    end
  end

  assign cnt0_o = cnt_q[0];
  assign cnt1_o = cnt_q[1];
  assign cnt2_o = cnt_q[2];
  assign cnt3_o = cnt_q[3];
`endif

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed-vector bench for stream_demux_1_4; covers counters too when STREAM_DEMUX_COUNT_EN is defined.
module tb_stream_demux_1_4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_sel;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [3:0] out_data0, out_data1, out_data2, out_data3;
`ifdef STREAM_DEMUX_COUNT_EN
  logic [7:0] cnt0, cnt1, cnt2, cnt3;
`endif

  int n_vec = 0;
  int n_bad = 0;

  stream_demux_1_4 #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_sel_i    (in_sel),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data0_o (out_data0),
    .out_data1_o (out_data1),
    .out_data2_o (out_data2),
    .out_data3_o (out_data3)
`ifdef STREAM_DEMUX_COUNT_EN
    ,
    .cnt0_o      (cnt0),
    .cnt1_o      (cnt1),
    .cnt2_o      (cnt2),
    .cnt3_o      (cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       vld;
    logic [1:0] sel;
    logic [3:0] dat;
    logic [3:0] rdy;
    logic       exp_rdy;
    logic [3:0] exp_ov;
    logic [3:0] exp_d0;
    logic [3:0] exp_d1;
    logic [3:0] exp_d2;
    logic [3:0] exp_d3;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ch_data(input int ch);
    case (ch)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  task automatic drive(input logic r, input logic v, input logic [1:0] s, input logic [3:0] d,
                       input logic [3:0] rd);
    rst_n     = r;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = rd;
  endtask

  initial begin
    drive(1'b0, 1'b0, 2'd0, 4'h0, 4'b0000);

    // outputs in each row describe the state before the row's clock edge
    vecs[0]  = '{1'b0, 1'b1, 2'd2, 4'hF, 4'b1111, 1'b1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[1]  = '{1'b1, 1'b1, 2'd2, 4'hA, 4'b1111, 1'b1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 4'h0, 4'b0000, 1'b1, 4'b0100, 4'h0, 4'h0, 4'hA, 4'h0};
    vecs[3]  = '{1'b1, 1'b1, 2'd0, 4'h1, 4'b0000, 1'b1, 4'b0100, 4'h0, 4'h0, 4'hA, 4'h0};
    vecs[4]  = '{1'b1, 1'b1, 2'd0, 4'h2, 4'b0000, 1'b0, 4'b0101, 4'h1, 4'h0, 4'hA, 4'h0};
    vecs[5]  = '{1'b1, 1'b1, 2'd1, 4'h3, 4'b0000, 1'b1, 4'b0101, 4'h1, 4'h0, 4'hA, 4'h0};
    vecs[6]  = '{1'b1, 1'b0, 2'd1, 4'h0, 4'b0000, 1'b0, 4'b0111, 4'h1, 4'h3, 4'hA, 4'h0};
    vecs[7]  = '{1'b1, 1'b0, 2'd0, 4'h0, 4'b1111, 1'b1, 4'b0111, 4'h1, 4'h3, 4'hA, 4'h0};
    vecs[8]  = '{1'b1, 1'b0, 2'd3, 4'h0, 4'b0000, 1'b1, 4'b0000, 4'h1, 4'h3, 4'hA, 4'h0};
    vecs[9]  = '{1'b1, 1'b1, 2'd3, 4'h5, 4'b0000, 1'b1, 4'b0000, 4'h1, 4'h3, 4'hA, 4'h0};
    vecs[10] = '{1'b1, 1'b1, 2'd3, 4'h6, 4'b1000, 1'b1, 4'b1000, 4'h1, 4'h3, 4'hA, 4'h5};
    vecs[11] = '{1'b1, 1'b0, 2'd3, 4'h0, 4'b0000, 1'b0, 4'b1000, 4'h1, 4'h3, 4'hA, 4'h6};
    vecs[12] = '{1'b1, 1'b1, 2'd0, 4'h7, 4'b0000, 1'b1, 4'b1000, 4'h1, 4'h3, 4'hA, 4'h6};
    vecs[13] = '{1'b1, 1'b1, 2'd1, 4'h8, 4'b0000, 1'b1, 4'b1001, 4'h7, 4'h3, 4'hA, 4'h6};
    vecs[14] = '{1'b1, 1'b1, 2'd2, 4'h9, 4'b0000, 1'b1, 4'b1011, 4'h7, 4'h8, 4'hA, 4'h6};
    vecs[15] = '{1'b1, 1'b1, 2'd1, 4'hB, 4'b1111, 1'b1, 4'b1111, 4'h7, 4'h8, 4'h9, 4'h6};
    vecs[16] = '{1'b1, 1'b0, 2'd0, 4'h0, 4'b0000, 1'b1, 4'b0010, 4'h7, 4'hB, 4'h9, 4'h6};
    vecs[17] = '{1'b1, 1'b1, 2'd1, 4'hC, 4'b0000, 1'b0, 4'b0010, 4'h7, 4'hB, 4'h9, 4'h6};
    vecs[18] = '{1'b1, 1'b0, 2'd0, 4'h0, 4'b0010, 1'b1, 4'b0010, 4'h7, 4'hB, 4'h9, 4'h6};
    vecs[19] = '{1'b1, 1'b0, 2'd0, 4'h0, 4'b0000, 1'b1, 4'b0000, 4'h7, 4'hB, 4'h9, 4'h6};

    for (int v = 0; v < 20; v++) begin
      @(negedge clk);
      drive(vecs[v].rst_n, vecs[v].vld, vecs[v].sel, vecs[v].dat, vecs[v].rdy);
      #2;
      chk($sformatf("vec%0d", v),
          {11'd0, in_ready, out_valid, out_data0, out_data1, out_data2, out_data3},
          {11'd0, vecs[v].exp_rdy, vecs[v].exp_ov, vecs[v].exp_d0, vecs[v].exp_d1,
           vecs[v].exp_d2, vecs[v].exp_d3});
    end

    // Streaming: beat k goes to channel k%4 with data k and is seen exactly one cycle later.
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k < 16) drive(1'b1, 1'b1, 2'(k % 4), 4'(k), 4'b1111);
      else        drive(1'b1, 1'b0, 2'd0, 4'h0, 4'b1111);
      #2;
      chk($sformatf("stream_rdy%0d", k), {31'd0, in_ready}, 32'd1);
      if (k == 0) begin
        chk("stream_ov0", {28'd0, out_valid}, 32'd0);
      end else if (k <= 16) begin
        chk($sformatf("stream_ov%0d", k), {28'd0, out_valid}, 32'(4'b0001 << ((k - 1) % 4)));
        chk($sformatf("stream_d%0d", k), {28'd0, ch_data((k - 1) % 4)}, 32'(k - 1));
      end else begin
        chk("stream_ov_end", {28'd0, out_valid}, 32'd0);
      end
    end

    // Fill channels 0..2 with the sinks stalled, then reset between edges.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 2'(k), 4'(k + 1), 4'b0000);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd0, 4'h0, 4'b0000);
    #1;
    chk("pre_rst_ov", {28'd0, out_valid}, 32'h7);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {12'd0, out_valid, out_data0, out_data1, out_data2, out_data3}, 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd0, 4'h0, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      chk($sformatf("post_rst_idle%0d", k), {28'd0, out_valid}, 32'd0);
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd0, 4'hD, 4'b1111);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd0, 4'h0, 4'b1111);
    #2;
    chk("post_rst_beat", {24'd0, out_valid, out_data0}, {24'd0, 4'b0001, 4'hD});

`ifdef STREAM_DEMUX_COUNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("cnt_rst", {cnt0, cnt1, cnt2, cnt3}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 258; k++) begin
      @(negedge clk);
      if (k < 257) drive(1'b1, 1'b1, 2'd1, 4'(k), 4'b0010);
      else         drive(1'b1, 1'b0, 2'd1, 4'h0, 4'b0010);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd0, 4'h0, 4'b0000);
    #2;
    chk("cnt_wrap", {cnt0, cnt1, cnt2, cnt3}, {8'd0, 8'd1, 8'd0, 8'd0});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
